draw_field: RTL

- Parametrised background stage for the air hockey video pipeline; the next generation of the plain background renderer.
- Consumes VGA timing (hcount/vcount/sync/blank) from the timing generator, draws the rink (border, goal mouths, centre line, centre ring, ice fill), and forwards timing to the puck/mallet overlay stages.
- Adds a registered display mode, a 2-stage pipeline, and a goal-flash state machine driven by score events.

---
 rtl/draw_field_if.sv | 13 +
 rtl/draw_field.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_field_if.sv
// VGA timing bundle (counts, syncs, blanking) passed between video pipeline stages.
// The timing generator side drives it through master; a consuming stage reads it through slave.
interface draw_field_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;

    modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk);
    modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/draw_field.sv
// Air hockey rink background stage: two-stage pipeline that paints the field from input-side
// counts, with a per-frame display mode and a goal-flash state machine driven by score pulses.
module draw_field #(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int BORDER_W     = 8,
    parameter int GOAL_HALF    = 96,
    parameter int LINE_W       = 4,
    parameter int R_IN         = 90,
    parameter int R_OUT        = 96,
    parameter int BLINK_FRAMES = 8,
    parameter int FLASH_FRAMES = 96
) (
    input  logic              clk_in,
    input  logic              rst,
    draw_field_if.slave       tin,
    draw_field_if.master      tout,
    input  logic [1:0]        mode_in,
    input  logic              goal_left,
    input  logic              goal_right,
    output logic [3:0]        r_out,
    output logic [3:0]        g_out,
    output logic [3:0]        b_out,
    output logic              flash_active
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    localparam logic [11:0] H_MID  = 12'(H_ACTIVE / 2);
    localparam logic [11:0] V_MID  = 12'(V_ACTIVE / 2);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BW     = 12'(BORDER_W);
    localparam logic [11:0] H_BR   = 12'(H_ACTIVE - BORDER_W);
    localparam logic [11:0] V_BR   = 12'(V_ACTIVE - BORDER_W);

    localparam logic signed [12:0] GOAL_S = 13'(GOAL_HALF);
    localparam logic signed [12:0] LINE_S = 13'(LINE_W / 2);

    localparam logic [24:0] R_IN_SQ  = 25'(R_IN * R_IN);
    localparam logic [24:0] R_OUT_SQ = 25'(R_OUT * R_OUT);

    localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_C  = CW'(BLINK_FRAMES);

    typedef enum logic [1:0] {IDLE, FLASH_L, FLASH_R} state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    mode_r;

    // Stage 1 combinational geometry from the incoming counts
    logic               tick_s;
    logic signed [12:0] dx_s;
    logic signed [12:0] dy_s;
    logic signed [23:0] dx_ext_s;
    logic signed [23:0] dy_ext_s;
    logic signed [23:0] dx_sq_s;
    logic signed [23:0] dy_sq_s;
    logic               goal_band_s;
    logic               edge_l_s;
    logic               edge_r_s;
    logic               edge_t_s;
    logic               edge_b_s;

    assign tick_s      = (tin.hcount == 12'd0) && (tin.vcount == 12'd0);
    assign dx_s        = $signed({1'b0, tin.hcount}) - $signed({1'b0, H_MID});
    assign dy_s        = $signed({1'b0, tin.vcount}) - $signed({1'b0, V_MID});
    assign dx_ext_s    = 24'(dx_s);
    assign dy_ext_s    = 24'(dy_s);
    assign dx_sq_s     = dx_ext_s * dx_ext_s;
    assign dy_sq_s     = dy_ext_s * dy_ext_s;
    assign goal_band_s = (dy_s > -GOAL_S) && (dy_s < GOAL_S);
    assign edge_l_s    = tin.hcount < BW;
    assign edge_r_s    = tin.hcount >= H_BR;
    assign edge_t_s    = tin.vcount < BW;
    assign edge_b_s    = tin.vcount >= V_BR;

    // Stage 1 registers
    logic [11:0] h1_r, v1_r;
    logic        hs1_r, hb1_r, vs1_r, vb1_r;
    logic        blank1_r, border1_r, goal_l1_r, goal_r1_r, line1_r;
    logic        top1_r, bot1_r, lft1_r, rgt1_r;
    logic [23:0] dx2_r, dy2_r;

    // Stage 1: delay timing and capture region flags and squared offsets
    always_ff @(posedge clk_in) begin
        if (rst) begin
            h1_r      <= 12'd0;
            v1_r      <= 12'd0;
            hs1_r     <= 1'b0;
            hb1_r     <= 1'b0;
            vs1_r     <= 1'b0;
            vb1_r     <= 1'b0;
            blank1_r  <= 1'b0;
            border1_r <= 1'b0;
            goal_l1_r <= 1'b0;
            goal_r1_r <= 1'b0;
            line1_r   <= 1'b0;
            top1_r    <= 1'b0;
            bot1_r    <= 1'b0;
            lft1_r    <= 1'b0;
            rgt1_r    <= 1'b0;
            dx2_r     <= 24'd0;
            dy2_r     <= 24'd0;
        end else begin
            h1_r      <= tin.hcount;
            v1_r      <= tin.vcount;
            hs1_r     <= tin.hsync;
            hb1_r     <= tin.hblnk;
            vs1_r     <= tin.vsync;
            vb1_r     <= tin.vblnk;
            blank1_r  <= tin.hblnk | tin.vblnk;
            border1_r <= edge_l_s | edge_r_s | edge_t_s | edge_b_s;
            goal_l1_r <= edge_l_s & goal_band_s;
            goal_r1_r <= edge_r_s & goal_band_s;
            line1_r   <= (dx_s > -LINE_S) && (dx_s < LINE_S);
            top1_r    <= tin.vcount == 12'd0;
            bot1_r    <= tin.vcount == V_LAST;
            lft1_r    <= tin.hcount == 12'd0;
            rgt1_r    <= tin.hcount == H_LAST;
            dx2_r     <= dx_sq_s;
            dy2_r     <= dy_sq_s;
        end
    end

    // Mode is only sampled on the frame tick so a frame never changes style part-way
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_r <= 2'd0;
        end else if (tick_s) begin
            mode_r <= mode_in;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Goal flash FSM; frame counter restarts on entry and ends the flash at FLASH_FRAMES ticks
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            flash_active <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (goal_left) begin
                        state_r      <= FLASH_L;
                        flash_active <= 1'b1;
                    end else if (goal_right) begin
                        state_r      <= FLASH_R;
                        flash_active <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                        flash_active <= 1'b0;
                    end
                end
                FLASH_L, FLASH_R: begin
                    if (tick_s && (cnt_r == CNT_LAST)) begin
                        state_r      <= IDLE;
                        cnt_r        <= '0;
                        flash_active <= 1'b0;
                    end else if (tick_s) begin
                        cnt_r        <= cnt_r + CW'(1);
                        flash_active <= 1'b1;
                    end else begin
                        flash_active <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= '0;
                    flash_active <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2 combinational colour selection
    logic [24:0] d2_s;
    logic        ring_s;
    logic        phase_on_s;
    logic [11:0] goal_col_s;
    logic [11:0] rgb_s;

    assign d2_s       = 25'(dx2_r) + 25'(dy2_r);
    assign ring_s     = (d2_s >= R_IN_SQ) && (d2_s <= R_OUT_SQ);
    assign phase_on_s = ((cnt_r / BLINK_C) & CW'(1)) == CW'(0);

    // Goal mouth lights only for the goal owning the current flash, during its on phase
    always_comb begin
        goal_col_s = 12'h000;
        if (goal_l1_r && (state_r == FLASH_L) && phase_on_s) begin
            goal_col_s = 12'h0F0;
        end else if (goal_r1_r && (state_r == FLASH_R) && phase_on_s) begin
            goal_col_s = 12'h0F0;
        end else begin
            goal_col_s = 12'h000;
        end
    end

    // Per-mode colour with region priority
    always_comb begin
        rgb_s = 12'h000;
        case (mode_r)
            2'd0: begin
                if (blank1_r) begin
                    rgb_s = 12'h000;
                end else if (goal_l1_r || goal_r1_r) begin
                    rgb_s = goal_col_s;
                end else if (border1_r) begin
                    rgb_s = 12'h00F;
                end else if (line1_r || ring_s) begin
                    rgb_s = 12'hF00;
                end else begin
                    rgb_s = 12'hDDF;
                end
            end
            2'd1: begin
                if (blank1_r) begin
                    rgb_s = 12'h000;
                end else begin
                    rgb_s = 12'hDDF;
                end
            end
            2'd2: begin
                if (blank1_r) begin
                    rgb_s = 12'h000;
                end else if (top1_r) begin
                    rgb_s = 12'hFF0;
                end else if (bot1_r) begin
                    rgb_s = 12'hF00;
                end else if (lft1_r) begin
                    rgb_s = 12'h0F0;
                end else if (rgt1_r) begin
                    rgb_s = 12'h00F;
                end else begin
                    rgb_s = 12'h888;
                end
            end
            default: rgb_s = 12'h000;
        endcase
    end

    logic [11:0] rgb_r;

    // Stage 2: register colour and second timing delay
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rgb_r       <= 12'h000;
            tout.hcount <= 12'd0;
            tout.vcount <= 12'd0;
            tout.hsync  <= 1'b0;
            tout.hblnk  <= 1'b0;
            tout.vsync  <= 1'b0;
            tout.vblnk  <= 1'b0;
        end else begin
            rgb_r       <= rgb_s;
            tout.hcount <= h1_r;
            tout.vcount <= v1_r;
            tout.hsync  <= hs1_r;
            tout.hblnk  <= hb1_r;
            tout.vsync  <= vs1_r;
            tout.vblnk  <= vb1_r;
        end
    end

    assign r_out = rgb_r[11:8];
    assign g_out = rgb_r[7:4];
    assign b_out = rgb_r[3:0];
endmodule
